// File: rtl/ibex_csr_bank.sv
// Bank of NumRegs hardened CSRs with write/set/clear, writable-bit masks, per-register lock,
// optional inverted shadow copies and a sticky integrity alert. Background scrub: IBEX_CSR_BANK_SCRUB_EN.
module ibex_csr_bank #(
    parameter int unsigned                NumRegs    = 4,
    parameter int unsigned                Width      = 32,
    parameter bit                         ShadowCopy = 1'b1,
    parameter logic [NumRegs*Width-1:0]   ResetValue = '0,
    parameter logic [NumRegs*Width-1:0]   WrMask     = '1,
    parameter int unsigned                AddrW      = (NumRegs > 1) ? $clog2(NumRegs) : 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               req_i,
    input  logic [1:0]         op_i,
    input  logic [AddrW-1:0]   addr_i,
    input  logic [Width-1:0]   wdata_i,
    input  logic               lock_i,
    output logic [Width-1:0]   rdata_o,
    output logic               rd_error_o,
    output logic               wr_ignored_o,
    output logic [NumRegs-1:0] locked_o,
    output logic               alert_o,
    output logic [AddrW-1:0]   alert_idx_o,
    input  logic               alert_clr_i
);

    localparam logic [1:0] OpRead  = 2'b00;
    localparam logic [1:0] OpWrite = 2'b01;
    localparam logic [1:0] OpSet   = 2'b10;
    localparam logic [1:0] OpClear = 2'b11;

    logic [NumRegs-1:0][Width-1:0] data_q;
    logic [NumRegs-1:0][Width-1:0] shadow_q;
    logic [NumRegs-1:0]            locked_q;
    logic                          alert_q;
    logic [AddrW-1:0]              alert_idx_q;
    logic                          wr_ignored_q;

    logic [Width-1:0] cur_data;
    logic [Width-1:0] cur_shadow;
    logic [Width-1:0] cur_mask;
    logic             cur_locked;
    logic             addr_valid;
    logic [Width-1:0] op_result;
    logic [Width-1:0] new_val;
    logic             modify;
    logic             do_update;
    logic             acc_err;
    logic             scrub_err;
    logic [AddrW-1:0] scrub_idx;

    // Addressed-register mux; an out-of-range index matches nothing and reads as zero.
    always_comb begin
        cur_data   = '0;
        cur_shadow = '0;
        cur_mask   = '0;
        cur_locked = 1'b0;
        addr_valid = 1'b0;
        for (int unsigned i = 0; i < NumRegs; i++) begin
            if (addr_i == AddrW'(i)) begin
                cur_data   = data_q[i];
                cur_shadow = shadow_q[i];
                cur_mask   = WrMask[i*Width +: Width];
                cur_locked = locked_q[i];
                addr_valid = 1'b1;
            end
        end
    end

    always_comb begin
        op_result = cur_data;
        case (op_i)
            OpWrite: op_result = wdata_i;
            OpSet:   op_result = cur_data | wdata_i;
            OpClear: op_result = cur_data & ~wdata_i;
            default: op_result = cur_data;
        endcase
    end

    assign new_val   = (cur_data & ~cur_mask) | (op_result & cur_mask);
    assign modify    = req_i && (op_i != OpRead);
    assign do_update = modify && addr_valid && !cur_locked;
    assign acc_err   = ShadowCopy && req_i && addr_valid && (cur_data != ~cur_shadow);

`ifdef IBEX_CSR_BANK_SCRUB_EN
    logic [AddrW-1:0] scrub_ptr_q;
    logic [Width-1:0] scrub_data;
    logic [Width-1:0] scrub_shadow;
    logic             scrub_hold;

    always_comb begin
        scrub_data   = '0;
        scrub_shadow = '0;
        for (int unsigned i = 0; i < NumRegs; i++) begin
            if (scrub_ptr_q == AddrW'(i)) begin
                scrub_data   = data_q[i];
                scrub_shadow = shadow_q[i];
            end
        end
    end

    // Hold on a register being modified so its in-flight update is never compared half-done.
    assign scrub_hold = modify && (addr_i == scrub_ptr_q);
    assign scrub_err  = ShadowCopy && (scrub_data != ~scrub_shadow);
    assign scrub_idx  = scrub_ptr_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            scrub_ptr_q <= '0;
        end else if (!scrub_hold) begin
            scrub_ptr_q <= (scrub_ptr_q == AddrW'(NumRegs - 1)) ? '0 : scrub_ptr_q + AddrW'(1);
        end
    end
`else
    assign scrub_err = 1'b0;
    assign scrub_idx = '0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q       <= ResetValue;
            locked_q     <= '0;
            alert_q      <= 1'b0;
            alert_idx_q  <= '0;
            wr_ignored_q <= 1'b0;
        end else begin
            wr_ignored_q <= modify && (!addr_valid || cur_locked);
            for (int unsigned i = 0; i < NumRegs; i++) begin
                if (addr_i == AddrW'(i)) begin
                    if (do_update) begin
                        data_q[i] <= new_val;
                    end
                    if (req_i && lock_i) begin
                        locked_q[i] <= 1'b1;
                    end
                end
            end
            // A fresh mismatch wins over a same-cycle clear; the first capture is otherwise kept.
            if ((acc_err || scrub_err) && (!alert_q || alert_clr_i)) begin
                alert_q     <= 1'b1;
                alert_idx_q <= acc_err ? addr_i : scrub_idx;
            end else if (alert_clr_i) begin
                alert_q     <= 1'b0;
                alert_idx_q <= '0;
            end
        end
    end

    if (ShadowCopy) begin : g_shadow
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                shadow_q <= ~ResetValue;
            end else begin
                for (int unsigned i = 0; i < NumRegs; i++) begin
                    if (do_update && (addr_i == AddrW'(i))) begin
                        shadow_q[i] <= ~new_val;
                    end
                end
            end
        end
    end else begin : g_no_shadow
        assign shadow_q = '0;
    end

    assign rdata_o      = cur_data;
    assign rd_error_o   = acc_err;
    assign wr_ignored_o = wr_ignored_q;
    assign locked_o     = locked_q;
    assign alert_o      = alert_q;
    assign alert_idx_o  = alert_idx_q;

endmodule

// File: tb/tb_ibex_csr_bank.sv
// Directed bench for ibex_csr_bank: vector table plus corruption, scrub and out-of-range sequences.
module tb_ibex_csr_bank;

    localparam logic [1:0] OP_R = 2'b00;
    localparam logic [1:0] OP_W = 2'b01;
    localparam logic [1:0] OP_S = 2'b10;
    localparam logic [1:0] OP_C = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        req = 1'b0, lock = 1'b0, clr = 1'b0;
    logic [1:0]  op = OP_R;
    logic [1:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        rd_error, wr_ign, alert;
    logic [3:0]  locked;
    logic [1:0]  alert_idx;

    logic        req5 = 1'b0, lock5 = 1'b0, clr5 = 1'b0;
    logic [1:0]  op5 = OP_R;
    logic [2:0]  addr5 = '0;
    logic [31:0] wdata5 = '0;
    logic [31:0] rdata5;
    logic        rd_error5, wr_ign5, alert5;
    logic [4:0]  locked5;
    logic [2:0]  alert_idx5;

    ibex_csr_bank #(
        .NumRegs(4), .Width(32), .ShadowCopy(1'b1),
        .ResetValue({32'h0, 32'h0, 32'hA5A5_0000, 32'h0}),
        .WrMask({32'hFFFF_FFFF, 32'h0000_00FF, 32'hFFFF_FFFF, 32'hFFFF_FFFF})
    ) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .op_i(op), .addr_i(addr), .wdata_i(wdata),
        .lock_i(lock), .rdata_o(rdata), .rd_error_o(rd_error), .wr_ignored_o(wr_ign),
        .locked_o(locked), .alert_o(alert), .alert_idx_o(alert_idx), .alert_clr_i(clr)
    );

    ibex_csr_bank #(.NumRegs(5), .Width(32)) dut5 (
        .clk_i(clk), .rst_i(rst), .req_i(req5), .op_i(op5), .addr_i(addr5), .wdata_i(wdata5),
        .lock_i(lock5), .rdata_o(rdata5), .rd_error_o(rd_error5), .wr_ignored_o(wr_ign5),
        .locked_o(locked5), .alert_o(alert5), .alert_idx_o(alert_idx5), .alert_clr_i(clr5)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        req;
        logic [1:0]  op;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic        lock;
        logic [31:0] exp_rdata;
        logic        exp_ign;
        logic [3:0]  exp_locked;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];
    logic [3:0][31:0] sh_bad;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Expected rdata is the pre-update value; exp_ign reflects the previous vector.
        vecs[0]  = '{1'b1, OP_R, 2'd0, 32'h0,         1'b0, 32'h0000_0000, 1'b0, 4'h0};
        vecs[1]  = '{1'b1, OP_R, 2'd1, 32'h0,         1'b0, 32'hA5A5_0000, 1'b0, 4'h0};
        vecs[2]  = '{1'b1, OP_R, 2'd2, 32'h0,         1'b0, 32'h0000_0000, 1'b0, 4'h0};
        vecs[3]  = '{1'b1, OP_R, 2'd3, 32'h0,         1'b0, 32'h0000_0000, 1'b0, 4'h0};
        vecs[4]  = '{1'b1, OP_W, 2'd2, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1'b0, 4'h0};
        vecs[5]  = '{1'b1, OP_S, 2'd2, 32'h0,         1'b0, 32'h0000_00FF, 1'b0, 4'h0};
        vecs[6]  = '{1'b1, OP_C, 2'd2, 32'h0000_000F, 1'b0, 32'h0000_00FF, 1'b0, 4'h0};
        vecs[7]  = '{1'b1, OP_R, 2'd2, 32'h0,         1'b0, 32'h0000_00F0, 1'b0, 4'h0};
        vecs[8]  = '{1'b1, OP_W, 2'd0, 32'h0000_1234, 1'b1, 32'h0000_0000, 1'b0, 4'h0};
        vecs[9]  = '{1'b1, OP_W, 2'd0, 32'h0000_5678, 1'b0, 32'h0000_1234, 1'b0, 4'h1};
        vecs[10] = '{1'b1, OP_R, 2'd0, 32'h0,         1'b0, 32'h0000_1234, 1'b1, 4'h1};
        vecs[11] = '{1'b1, OP_R, 2'd0, 32'h0,         1'b0, 32'h0000_1234, 1'b0, 4'h1};
        vecs[12] = '{1'b1, OP_S, 2'd1, 32'h0000_00FF, 1'b0, 32'hA5A5_0000, 1'b0, 4'h1};
        vecs[13] = '{1'b1, OP_R, 2'd1, 32'h0,         1'b0, 32'hA5A5_00FF, 1'b0, 4'h1};
        vecs[14] = '{1'b1, OP_C, 2'd0, 32'h0000_FFFF, 1'b0, 32'h0000_1234, 1'b0, 4'h1};
        vecs[15] = '{1'b1, OP_R, 2'd3, 32'h0,         1'b0, 32'h0000_0000, 1'b1, 4'h1};
        vecs[16] = '{1'b1, OP_W, 2'd3, 32'hCAFE_0000, 1'b0, 32'h0000_0000, 1'b0, 4'h1};
        vecs[17] = '{1'b1, OP_R, 2'd3, 32'h0,         1'b0, 32'hCAFE_0000, 1'b0, 4'h1};
        vecs[18] = '{1'b0, OP_W, 2'd3, 32'h0,         1'b0, 32'hCAFE_0000, 1'b0, 4'h1};
        vecs[19] = '{1'b1, OP_R, 2'd3, 32'h0,         1'b0, 32'hCAFE_0000, 1'b0, 4'h1};

        // Reset must override a concurrent write-and-lock.
        @(posedge clk); #1;
        req = 1'b1; op = OP_W; addr = 2'd0; wdata = 32'hFFFF_FFFF; lock = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; req = 1'b0; op = OP_R; lock = 1'b0; wdata = '0;
        #1;
        chk("rst_rdata0", rdata, 32'h0);
        chk("rst_locked", 32'(locked), 32'h0);
        chk("rst_alert", 32'(alert), 32'h0);
        chk("rst_alert_idx", 32'(alert_idx), 32'h0);
        chk("rst_wr_ign", 32'(wr_ign), 32'h0);
        chk("rst_rdata5", rdata5, 32'h0);

        for (int k = 0; k < NV; k++) begin
            @(posedge clk); #1;
            req = vecs[k].req; op = vecs[k].op; addr = vecs[k].addr;
            wdata = vecs[k].wdata; lock = vecs[k].lock;
            #1;
            chk($sformatf("v%0d_rdata", k), rdata, vecs[k].exp_rdata);
            chk($sformatf("v%0d_wr_ign", k), 32'(wr_ign), 32'(vecs[k].exp_ign));
            chk($sformatf("v%0d_locked", k), 32'(locked), 32'(vecs[k].exp_locked));
            chk($sformatf("v%0d_rd_error", k), 32'(rd_error), 32'h0);
            chk($sformatf("v%0d_alert", k), 32'(alert), 32'h0);
        end

        // Corrupt bit 5 of reg3's shadow and read it.
        @(posedge clk); #1;
        lock = 1'b0;
        sh_bad[0] = ~32'h0000_1234;
        sh_bad[1] = ~32'hA5A5_00FF;
        sh_bad[2] = ~32'h0000_00F0;
        sh_bad[3] = ~32'hCAFE_0000 ^ 32'h0000_0020;
        force dut.shadow_q = sh_bad;
        req = 1'b1; op = OP_R; addr = 2'd3;
        #1;
        chk("corr3_rd_error", 32'(rd_error), 32'h1);
        chk("corr3_alert_same_cycle", 32'(alert), 32'h0);
        @(posedge clk); #2;
        chk("corr3_alert", 32'(alert), 32'h1);
        chk("corr3_alert_idx", 32'(alert_idx), 32'h3);

        sh_bad[1] = sh_bad[1] ^ 32'h0000_0002;
        force dut.shadow_q = sh_bad;
        addr = 2'd1;
        #1;
        chk("corr1_rd_error", 32'(rd_error), 32'h1);
        @(posedge clk); #2;
        chk("corr1_alert", 32'(alert), 32'h1);
        chk("corr1_alert_idx_kept", 32'(alert_idx), 32'h3);

        addr = 2'd3; clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0; req = 1'b0;
        #1;
        chk("clr_vs_set_alert", 32'(alert), 32'h1);
        chk("clr_vs_set_idx", 32'(alert_idx), 32'h3);
`ifndef IBEX_CSR_BANK_SCRUB_EN
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        #1;
        chk("clr_alert", 32'(alert), 32'h0);
        chk("clr_alert_idx", 32'(alert_idx), 32'h0);
`endif
        release dut.shadow_q;

        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("rst2_locked", 32'(locked), 32'h0);
        chk("rst2_alert", 32'(alert), 32'h0);

        // Idle bus: only the background scrubber can see a corrupted reg2.
        sh_bad[0] = ~32'h0;
        sh_bad[1] = ~32'hA5A5_0000;
        sh_bad[2] = ~32'h0 ^ 32'h0000_0004;
        sh_bad[3] = ~32'h0;
        force dut.shadow_q = sh_bad;
        for (int n = 0; n < 6; n++) begin
            @(posedge clk); #2;
            if (alert) break;
        end
`ifdef IBEX_CSR_BANK_SCRUB_EN
        chk("scrub_alert", 32'(alert), 32'h1);
        chk("scrub_alert_idx", 32'(alert_idx), 32'h2);
`else
        chk("noscrub_alert", 32'(alert), 32'h0);
        chk("noscrub_alert_idx", 32'(alert_idx), 32'h0);
`endif
        release dut.shadow_q;

        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;

        // Five-register instance: index 5 is outside the bank.
        req5 = 1'b1; op5 = OP_W; addr5 = 3'd4; wdata5 = 32'h0000_DEAD;
        #1;
        chk("r5_w4_rdata_old", rdata5, 32'h0);
        @(posedge clk); #1;
        op5 = OP_W; addr5 = 3'd5; wdata5 = 32'h0000_FFFF;
        #1;
        chk("r5_oor_rdata", rdata5, 32'h0);
        chk("r5_oor_wr_ign_before", 32'(wr_ign5), 32'h0);
        @(posedge clk); #1;
        op5 = OP_R; addr5 = 3'd5;
        #1;
        chk("r5_oor_wr_ign", 32'(wr_ign5), 32'h1);
        chk("r5_oor_read", rdata5, 32'h0);
        @(posedge clk); #1;
        addr5 = 3'd4;
        #1;
        chk("r5_reg4", rdata5, 32'h0000_DEAD);
        chk("r5_read_no_ign", 32'(wr_ign5), 32'h0);
        for (int i = 0; i < 4; i++) begin
            addr5 = 3'(i);
            #1;
            chk($sformatf("r5_reg%0d_untouched", i), rdata5, 32'h0);
        end
        chk("r5_locked", 32'(locked5), 32'h0);
        chk("r5_rd_error", 32'(rd_error5), 32'h0);
        chk("r5_alert", 32'(alert5), 32'h0);
        req5 = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ibex_csr_bank.md
Name: ibex_csr_bank

Overview:
- Parametrised successor to the single-register CSR primitive. Holds NumRegs CSRs of Width bits each.
- Supports write, set and clear operations, per-bit writable masks and a per-register lock.
- With ShadowCopy, keeps an inverted shadow of every register. Reports mismatches per access and through a sticky alert; an optional background scrubber checks unaccessed registers.
- Sits between the CSR decode stage and hardened CSRs such as PMP config and security controls.

Parameters:
- NumRegs, 4: number of registers; minimum 1.
- Width, 32: bits per register.
- ShadowCopy, 1'b1: 1 keeps an inverted shadow per register; 0 removes the shadow, and every error output is tied to 0.
- ResetValue, {NumRegs*Width{1'b0}}: concatenated reset values; register i uses bits [i*Width +: Width].
- WrMask, {NumRegs*Width{1'b1}}: concatenated writable-bit masks; a 0 bit is read-only and holds its reset value.
- AddrW, $clog2(NumRegs) with minimum 1: derived width of the address.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- req_i  in  1  access valid this cycle.
- op_i  in  2  00 read, 01 write, 10 set, 11 clear.
- addr_i  in  AddrW  register index.
- wdata_i  in  Width  operand for write/set/clear.
- lock_i  in  1  with req_i, locks the addressed register after this access's update.
- rdata_o  out  Width  combinational value of register[addr_i].
- rd_error_o  out  1  combinational: addressed register mismatches its shadow.
- wr_ignored_o  out  1  registered: previous cycle's modifying op hit a locked register or an out-of-range address.
- locked_o  out  NumRegs  per-register lock state.
- alert_o  out  1  sticky integrity alert.
- alert_idx_o  out  AddrW  index of the first mismatch captured.
- alert_clr_i  in  1  clears alert_o and alert_idx_o.

Behaviour:
- Reset (rst_i=1 at an edge):
  - data_q[i]=ResetValue[i]; shadow_q[i]=~ResetValue[i].
  - locked_o=0, alert_o=0, alert_idx_o=0, wr_ignored_o=0.
  - Scrub pointer=0.
  - Reset overrides every other input in the same cycle.
- Update rule: on req_i with op≠00, addr<NumRegs and the register not locked:
  - new = (old & ~WrMask) | (f(old,wdata) & WrMask).
  - f: write=wdata, set=old|wdata, clear=old&~wdata.
  - Takes effect at the next edge: 1-cycle write latency; rdata_o shows the old value during the access cycle.
  - shadow_q gets ~new at the same edge.
- Ignored ops: op≠00 to a locked register or to addr≥NumRegs → no state change; wr_ignored_o=1 for exactly the following cycle.
- Reads: rdata_o=0 when addr≥NumRegs. Reads never set wr_ignored_o.
- Locking:
  - lock_i with req_i and a valid addr sets locked_o[addr] at the edge, after the same cycle's update applies. "Write value and lock" is therefore atomic.
  - Lock persists until rst_i; nothing else clears it.
- rd_error_o = ShadowCopy && req_i && addr valid && (data_q[addr] != ~shadow_q[addr]).
- Alert capture:
  - If alert_o=0 and a mismatch is detected (access or scrub), alert_o←1 and alert_idx_o←that index at the next edge.
  - An access mismatch has priority over a scrub mismatch in the same cycle.
  - Further mismatches do not overwrite alert_idx_o.
- alert_clr_i: clears alert_o and alert_idx_o at the edge. If a new mismatch is detected in the same cycle, it is captured instead: set wins over clear.
- A mismatched register is not auto-repaired; a subsequent successful write rewrites both copies and removes the mismatch.
- ShadowCopy=0: no shadow storage; rd_error_o=0, alert_o=0, alert_idx_o=0 constant.

Optional Feature:
- Macro: IBEX_CSR_BANK_SCRUB_EN.
- Defined (and ShadowCopy=1):
  - The scrub pointer advances 0→NumRegs-1 and wraps to 0, one register per cycle.
  - It compares data_q[ptr] against ~shadow_q[ptr] and feeds alert capture.
  - The pointer holds when req_i is high and addr_i==ptr with op≠00, so an in-flight update is not flagged.
  - Worst-case detection latency: NumRegs+1 cycles.
- Undefined: no pointer logic; alerts come only from accesses.

Test Plan:
- Reset, then read each index with ResetValue[1]=32'hA5A5_0000 → rdata_o=32'hA5A5_0000 at idx1, others 0; all error and alert outputs 0.
- Write 32'hFFFF_FFFF to idx2 with WrMask[2]=32'h0000_00FF, then set 32'h0 and clear 32'h0F → reads 32'h0000_00FF, then 32'h0000_00F0; upper bits hold reset value.
- Write 32'h1234 with lock_i=1 to idx0, next cycle write 32'h5678 → rdata 32'h1234; wr_ignored_o=1 for one cycle; locked_o[0]=1 until rst_i.
- Force shadow_q[3] bit 5 to flip, then read idx3 → rd_error_o=1 in the same cycle; alert_o=1 and alert_idx_o=3 next cycle. A second flip on idx1 leaves alert_idx_o=3. alert_clr_i together with a continued idx3 read keeps alert_o=1.
- SCRUB_EN, NumRegs=4: corrupt idx2 with no accesses → alert_o=1, alert_idx_o=2 within 5 cycles. Same case without the macro → alert_o stays 0.
- Access to addr=5 with NumRegs=5 and AddrW=3 → rdata_o=0; a write sets wr_ignored_o=1; no register changes.
